// File: rtl/requant_pipe.sv
// requant_pipe: 3-stage streaming requantizer (multiply, rounding shift, zero-point add + saturate).
// Optional: define REQUANT_RELU_EN to fuse a ReLU6-style clamp [zp, zp+MAX_VAL] into the last stage.
module requant_pipe #(
   parameter int BITWIDTH    = 8,
   parameter int ACC_WIDTH   = 32,
   parameter int MULT_WIDTH  = 16,
   parameter int SHIFT_WIDTH = 5,
   parameter int MAX_VAL     = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_load,
   input  logic        [MULT_WIDTH-1:0]  cfg_mult,
   input  logic        [SHIFT_WIDTH-1:0] cfg_shift,
   input  logic signed [BITWIDTH-1:0]    cfg_zp,
   output logic                          cfg_busy,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [ACC_WIDTH-1:0]   in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [BITWIDTH-1:0]    out_data,
   output logic        [15:0]            sat_count
);
   localparam int PW = ACC_WIDTH + MULT_WIDTH + 1;
   localparam int RW = PW + 1;
   localparam int SW = RW + 1;
`ifdef REQUANT_RELU_EN
   localparam bit RELU_EN = 1'b1;
`else
   localparam bit RELU_EN = 1'b0;
`endif
   localparam logic signed [SW-1:0] FULL_LO   = {{(SW-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};
   localparam logic signed [SW-1:0] FULL_HI   = {{(SW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] RELU_SPAN = SW'(MAX_VAL);

   logic        [MULT_WIDTH-1:0]  cur_mult;
   logic        [SHIFT_WIDTH-1:0] cur_shift;
   logic signed [BITWIDTH-1:0]    cur_zp;

   logic adv, xfer, load_ok;
   logic vld_p0, vld_p1, vld_p2, sat_p2;
   logic signed [PW-1:0] prod_p0, prod, acc_ext, mult_ext;
   logic signed [RW-1:0] rnd_p1;
   logic signed [SW-1:0] zp_ext, sum, lo, hi;
   logic        [BITWIDTH:0] clamped;

   // Guard bit in the result keeps p + 2^(sh-1) from overflowing.
   function automatic logic signed [RW-1:0] round_shift(input logic signed [PW-1:0] p,
                                                        input logic [SHIFT_WIDTH-1:0] sh);
      logic signed [RW-1:0] pe;
      logic signed [RW-1:0] bias;
      pe = {p[PW-1], p};
      if (sh == '0) return pe;
      bias = {{(RW-1){1'b0}}, 1'b1} << (sh - SHIFT_WIDTH'(1));
      return (pe + bias) >>> sh;
   endfunction

   // MSB of the result is the saturation flag.
   function automatic logic [BITWIDTH:0] saturate(input logic signed [SW-1:0] s,
                                                  input logic signed [SW-1:0] l,
                                                  input logic signed [SW-1:0] h);
      if (s < l) return {1'b1, l[BITWIDTH-1:0]};
      if (s > h) return {1'b1, h[BITWIDTH-1:0]};
      return {1'b0, s[BITWIDTH-1:0]};
   endfunction

   assign adv       = !vld_p2 || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_p2;
   assign xfer      = in_valid && adv;
   assign cfg_busy  = vld_p0 || vld_p1 || vld_p2;
   assign load_ok   = cfg_load && !cfg_busy && !xfer;

   always_comb begin
      acc_ext  = {{(PW-ACC_WIDTH){in_data[ACC_WIDTH-1]}}, in_data};
      mult_ext = {{(PW-MULT_WIDTH){1'b0}}, cur_mult};
      prod     = acc_ext * mult_ext;
      zp_ext   = {{(SW-BITWIDTH){cur_zp[BITWIDTH-1]}}, cur_zp};
      sum      = {rnd_p1[RW-1], rnd_p1} + zp_ext;
      lo       = FULL_LO;
      hi       = FULL_HI;
      if (RELU_EN) begin
         lo = zp_ext;
         hi = (zp_ext + RELU_SPAN > FULL_HI) ? FULL_HI : zp_ext + RELU_SPAN;
      end
      clamped  = saturate(sum, lo, hi);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0    <= 1'b0;
         vld_p1    <= 1'b0;
         vld_p2    <= 1'b0;
         sat_p2    <= 1'b0;
         out_data  <= '0;
         cur_mult  <= '0;
         cur_shift <= '0;
         cur_zp    <= '0;
         sat_count <= '0;
      end else begin
         if (adv) begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            // stage p2: offset and saturate
            if (vld_p1) begin
               out_data <= clamped[BITWIDTH-1:0];
               sat_p2   <= clamped[BITWIDTH];
            end
         end
         if (load_ok) begin
            cur_mult  <= cfg_mult;
            cur_shift <= cfg_shift;
            cur_zp    <= cfg_zp;
            sat_count <= '0;
         end else if (vld_p2 && out_ready && sat_p2 && sat_count != 16'hFFFF) begin
            sat_count <= sat_count + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // stage p0: multiply
      if (adv && in_valid) prod_p0 <= prod;
      // stage p1: rounding shift
      if (adv && vld_p0) rnd_p1 <= round_shift(prod_p0, cur_shift);
   end
endmodule

// File: tb/tb_requant_pipe.sv
// Testbench for requant_pipe: directed cases plus randomized streaming against an arithmetic reference model.
module tb_requant_pipe;
   localparam int MAX_VAL = 6;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               cfg_load = 1'b0;
   logic [15:0]        cfg_mult = '0;
   logic [4:0]         cfg_shift = '0;
   logic signed [7:0]  cfg_zp = '0;
   logic               cfg_busy;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [31:0] in_data = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic signed [7:0]  out_data;
   logic [15:0]        sat_count;

   requant_pipe dut (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
      .cfg_zp(cfg_zp), .cfg_busy(cfg_busy), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sat_count(sat_count)
   );

   always #5 clk = ~clk;

   typedef struct { int d; bit sat; } exp_t;
   exp_t q[$];
   int   got[$];
   int   n_vec = 0;
   int   n_err = 0;
   logic [15:0]       m_mult = '0;
   logic [4:0]        m_shift = '0;
   logic signed [7:0] m_zp = '0;
   int                m_sat = 0;
   bit                prev_stall = 1'b0;
   int                prev_data = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic signed [31:0] acc);
      exp_t   e;
      longint p, r, s, lo, hi;
      int     sh;
      sh = int'(m_shift);
      p  = longint'(acc) * longint'(m_mult);
      if (sh == 0) r = p;
      else r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
      s  = r + longint'(m_zp);
      lo = -128;
      hi = 127;
`ifdef REQUANT_RELU_EN
      lo = longint'(m_zp);
      hi = longint'(m_zp) + MAX_VAL;
      if (hi > 127) hi = 127;
`endif
      e.sat = (s < lo) || (s > hi);
      e.d   = (s < lo) ? int'(lo) : (s > hi) ? int'(hi) : int'(s);
      return e;
   endfunction

   // Scoreboard: the set of words in flight is exactly what the block should call busy.
   always @(negedge clk) begin
      exp_t e;
      bit   xf;
      if (rst) begin
         q.delete();
         m_sat = 0; m_mult = '0; m_shift = '0; m_zp = '0;
         prev_stall = 1'b0;
         check("rst_out_valid", out_valid, 0);
         check("rst_sat_count", sat_count, 0);
      end else begin
         check("busy", cfg_busy, (q.size() != 0));
         check("in_ready", in_ready, (!out_valid || out_ready));
         check("sat_count", sat_count, m_sat);
         if (q.size() == 0) check("idle_out_valid", out_valid, 0);
         if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, prev_data);
         end
         xf = in_valid && in_ready;
         if (cfg_load && q.size() == 0 && !xf) begin
            m_mult = cfg_mult; m_shift = cfg_shift; m_zp = cfg_zp; m_sat = 0;
         end
         if (out_valid && out_ready) begin
            got.push_back(int'(out_data));
            if (q.size() == 0) check("unexpected_output", 1, 0);
            else begin
               e = q.pop_front();
               check("out_data", out_data, e.d);
               if (e.sat && m_sat != 16'hFFFF) m_sat++;
            end
         end
         if (xf) q.push_back(model(in_data));
         prev_stall = out_valid && !out_ready;
         prev_data  = int'(out_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_cfg(input int m, input int s, input int z);
      cfg_mult = 16'(m); cfg_shift = 5'(s); cfg_zp = 8'(z);
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid = 1'b0; out_ready = 1'b1; cfg_load = 1'b0;
      while (cfg_busy && n < 30) begin tick(); n++; end
      check("drain_timeout", cfg_busy, 0);
      tick();
   endtask

   task automatic send(input int ws[$]);
      foreach (ws[i]) begin
         int n;
         n = 0;
         in_valid = 1'b1; in_data = ws[i];
         #1;
         while (!in_ready && n < 30) begin tick(); n++; end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic check_got(input string tag, input int e[$]);
      check({tag, "_count"}, got.size(), e.size());
      foreach (e[i]) if (i < got.size()) check(tag, got[i], e[i]);
   endtask

   initial begin
      int ws[$];
      int ex[$];
      int idx;
      bit xf;
      tick(); tick();
      check("reset_out_data", out_data, 0);
      check("reset_busy", cfg_busy, 0);
      rst = 1'b0;
      tick();

      // Basic scaling and latency
      load_cfg(16384, 15, 0);
      in_valid = 1'b1; in_data = 100;
      tick();
      in_data = -100;
      check("lat_c1", out_valid, 0);
      tick();
      in_valid = 1'b0;
      check("lat_c2", out_valid, 0);
      tick();
      check("lat_c3_valid", out_valid, 1);
`ifdef REQUANT_RELU_EN
      check("lat_c3_data", out_data, 6);
`else
      check("lat_c3_data", out_data, 50);
`endif
      tick();
      check("lat_c4_valid", out_valid, 1);
`ifdef REQUANT_RELU_EN
      check("lat_c4_data", out_data, 0);
`else
      check("lat_c4_data", out_data, -50);
`endif
      tick();
      check("lat_c5_valid", out_valid, 0);
      drain();
`ifdef REQUANT_RELU_EN
      check("sat_after_t1", sat_count, 2);
`else
      check("sat_after_t1", sat_count, 0);
`endif

      // Full-range saturation
      got.delete();
      ws = '{1000, -1000}; send(ws); drain();
`ifdef REQUANT_RELU_EN
      ex = '{6, 0};   check_got("sat_vals", ex); check("sat_after_t2", sat_count, 4);
`else
      ex = '{127, -128}; check_got("sat_vals", ex); check("sat_after_t2", sat_count, 2);
`endif

      // Rounding half toward +inf, then zero shift and relu-style inputs
      load_cfg(1, 1, 0);
      check("sat_cleared", sat_count, 0);
      got.delete();
      ws = '{3, -3, 1, -1}; send(ws); drain();
`ifdef REQUANT_RELU_EN
      ex = '{2, 0, 1, 0};  check_got("round", ex); check("sat_round", sat_count, 1);
`else
      ex = '{2, -1, 1, 0}; check_got("round", ex); check("sat_round", sat_count, 0);
`endif
      load_cfg(1, 0, 0);
      got.delete();
      ws = '{5, -4, 3, 9}; send(ws); drain();
`ifdef REQUANT_RELU_EN
      ex = '{5, 0, 3, 6};  check_got("shift0", ex); check("sat_shift0", sat_count, 2);
`else
      ex = '{5, -4, 3, 9}; check_got("shift0", ex); check("sat_shift0", sat_count, 0);
`endif

      // Backpressure mid-stream
      load_cfg(1, 0, 0);
      got.delete();
      ws = '{-3, -2, -1, 0, 1, 2};
      idx = 0;
      for (int c = 0; c < 40 && idx < 6; c++) begin
         in_valid = 1'b1; in_data = ws[idx];
         out_ready = !(c >= 4 && c < 8);
         #1;
         xf = in_valid && in_ready;
         tick();
         if (xf) idx++;
      end
      drain();
`ifdef REQUANT_RELU_EN
      ex = '{0, 0, 0, 0, 1, 2};
`else
      ex = '{-3, -2, -1, 0, 1, 2};
`endif
      check_got("stall", ex);

      // Config loads: ignored while busy or with a transfer, honoured when idle
      load_cfg(2, 0, 1);
      got.delete();
      ws = '{5, 6}; send(ws);
      cfg_mult = 16'd3; cfg_zp = 8'sd0; cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      drain();
      ws = '{4}; send(ws); drain();
`ifdef REQUANT_RELU_EN
      ex = '{7, 7, 7};   check_got("busy_load", ex); check("sat_busy_load", sat_count, 3);
`else
      ex = '{11, 13, 9}; check_got("busy_load", ex); check("sat_busy_load", sat_count, 0);
`endif
      load_cfg(3, 0, 0);
      check("sat_cleared2", sat_count, 0);
      got.delete();
      in_valid = 1'b1; in_data = 1; cfg_mult = 16'd5; cfg_load = 1'b1;
      tick();
      in_valid = 1'b0; cfg_load = 1'b0;
      ws = '{1}; send(ws); drain();
      ex = '{3, 3}; check_got("xfer_load", ex);

      // Reset with two words in flight
      got.delete();
      in_valid = 1'b1; in_data = 7; tick();
      in_data = 8; tick();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_async_valid", out_valid, 0);
      check("rst_async_busy", cfg_busy, 0);
      check("rst_async_data", out_data, 0);
      tick(); tick();
      rst = 1'b0;
      repeat (8) tick();
      check("post_rst_outputs", got.size(), 0);

      // Randomized streaming with random backpressure and load attempts
      for (int r = 0; r < 4; r++) begin
         drain();
         load_cfg(int'($urandom_range(0, 65535)), int'($urandom_range(4, 20)),
                  int'($urandom_range(0, 255)));
         for (int c = 0; c < 150; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) in_data = $urandom;
            else in_data = int'($urandom_range(0, 4000)) - 2000;
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_load  = ($urandom_range(0, 19) == 0);
            if (cfg_load) begin
               cfg_mult  = 16'($urandom);
               cfg_shift = 5'($urandom);
               cfg_zp    = 8'($urandom);
            end
            tick();
         end
         cfg_load = 1'b0;
      end
      drain();
      check("final_queue_empty", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
